// File: rtl/game_pkg.sv
// Shared types for the play-flow controller. The HUD and renderer decode
// state_o using game_state_t, so the encoding below is part of the interface.
//   game_state_t    : MENU, COUNTDOWN, PLAY, PAUSE, OVER, WIN (3-bit)
//   counts_frames() : states in which the per-second frame counter runs
//   keeps_phase()   : transitions that keep the frame counter (pause/resume)
package game_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4,
    WIN       = 3'd5
  } game_state_t;

  function automatic logic counts_frames(input game_state_t s);
    return (s == COUNTDOWN) || (s == PLAY) || (s == OVER) || (s == WIN);
  endfunction

  // Pausing and resuming must not lose the partial second already played.
  function automatic logic keeps_phase(input game_state_t from_s,
                                       input game_state_t to_s);
    return ((from_s == PLAY) && (to_s == PAUSE)) ||
           ((from_s == PAUSE) && (to_s == PLAY));
  endfunction

endpackage

// File: rtl/frame_sec_divider.sv
// Divides video frames into seconds.
//   Clk, Reset : clock, synchronous active-high reset
//   clear      : zero the frame counter (dominates counting)
//   enable     : count frame_tick pulses
//   frame_tick : one-cycle pulse per video frame
//   sec_tick   : combinational pulse in the cycle the counter wraps
module frame_sec_divider #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  input  logic frame_tick,
  output logic sec_tick
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

  logic [CW-1:0] frame_cnt;

  // Same-cycle pulse so the controller can act on the wrapping frame itself.
  assign sec_tick = enable & frame_tick & (frame_cnt == LAST);

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      frame_cnt <= '0;
    end else if (enable && frame_tick) begin
      frame_cnt <= sec_tick ? '0 : frame_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_session_sequencer.sv
// Play-flow controller: menu, per-level countdown, timed play, pause and
// result screens. All timing is in video frames via frame_sec_divider.
//   Clk, Reset                : clock, synchronous active-high reset
//   frame_tick                : one pulse per video frame
//   start_key, pause_key      : level keys, rising edge acts
//   fire_dead, ice_dead       : hazard contact (level)
//   fire_at_door, ice_at_door : actor on its exit door (level)
//   state_o                   : current game_state_t (also the FSM debug view)
//   revive                    : one-cycle pulse to reload spawn positions
//   freeze                    : 1 while not in PLAY
//   level, countdown, time_left : HUD values
module game_session_sequencer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int COUNTDOWN_SEC   = 3,
  parameter int TIME_LIMIT_SEC  = 300,
  parameter int RESULT_HOLD_SEC = 3,
  parameter int NUM_LEVELS      = 3,
  parameter int LEVEL_W         = 2,
  parameter int TIME_W          = 9
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               fire_dead,
  input  logic               ice_dead,
  input  logic               fire_at_door,
  input  logic               ice_at_door,
  output game_state_t        state_o,
  output logic               revive,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         countdown,
  output logic [TIME_W-1:0]  time_left
);

  localparam int HOLD_W = $clog2(RESULT_HOLD_SEC + 1);
  localparam logic [1:0]         CD_LOAD    = 2'(COUNTDOWN_SEC);
  localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(TIME_LIMIT_SEC);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_HOLD_SEC - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

  game_state_t        state, state_n;
  logic [1:0]         countdown_n;
  logic [TIME_W-1:0]  time_left_n;
  logic [LEVEL_W-1:0] level_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               revive_n;

  logic start_q, pause_q, keys_armed;
  logic start_edge, pause_edge;
  logic sec_tick, div_clear, div_enable, hold_done;

  // keys_armed masks the first cycle after reset, so a key already held
  // while Reset was asserted never turns into a start or pause.
  assign start_edge = start_key & ~start_q & keys_armed;
  assign pause_edge = pause_key & ~pause_q & keys_armed;

  assign div_enable = counts_frames(state);
  assign div_clear  = (state == MENU) ||
                      ((state_n != state) && !keeps_phase(state, state_n));
  assign hold_done  = sec_tick && (hold_cnt == HOLD_LAST);
  assign state_o    = state;

  frame_sec_divider #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_sec_div (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (div_clear),
    .enable    (div_enable),
    .frame_tick(frame_tick),
    .sec_tick  (sec_tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= MENU;
      level      <= '0;
      countdown  <= '0;
      time_left  <= '0;
      revive     <= 1'b0;
      freeze     <= 1'b1;
      hold_cnt   <= '0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      keys_armed <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      countdown  <= countdown_n;
      time_left  <= time_left_n;
      revive     <= revive_n;
      freeze     <= (state_n != PLAY);
      hold_cnt   <= hold_n;
      start_q    <= start_key;
      pause_q    <= pause_key;
      keys_armed <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    countdown_n = countdown;
    time_left_n = time_left;
    level_n     = level;
    hold_n      = hold_cnt;
    revive_n    = 1'b0;
    case (state)
      MENU: begin
        if (start_edge) begin
          state_n     = COUNTDOWN;
          countdown_n = CD_LOAD;
        end
      end
      COUNTDOWN: begin
        if (sec_tick) begin
          if (countdown == 2'd1) begin
            state_n     = PLAY;
            countdown_n = '0;
            time_left_n = TIME_LOAD;
            revive_n    = 1'b1;
          end else begin
            countdown_n = countdown - 2'd1;
          end
        end
      end
      PLAY: begin
        // Death outranks everything, so touching a hazard on the door loses.
        if (fire_dead || ice_dead) begin
          state_n = OVER;
          hold_n  = '0;
        end else if (sec_tick && (time_left == TIME_W'(1))) begin
          state_n     = OVER;
          time_left_n = '0;
          hold_n      = '0;
        end else if (fire_at_door && ice_at_door) begin
          state_n = WIN;
          hold_n  = '0;
        end else if (pause_edge) begin
          state_n = PAUSE;
        end else if (sec_tick) begin
          time_left_n = time_left - TIME_W'(1);
        end
      end
      PAUSE: begin
        if (pause_edge) begin
          state_n = PLAY;
        end
      end
      OVER: begin
        if (start_edge || hold_done) begin
          state_n     = COUNTDOWN;
          countdown_n = CD_LOAD;
        end else if (sec_tick) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      WIN: begin
        if (start_edge || hold_done) begin
          if (level == LEVEL_LAST) begin
            state_n = MENU;
            level_n = '0;
          end else begin
            state_n     = COUNTDOWN;
            level_n     = level + LEVEL_W'(1);
            countdown_n = CD_LOAD;
          end
        end else if (sec_tick) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = MENU;
    endcase
  end

endmodule
